rob_commit_ctrl: RTL and testbench
==================================

// Module: rob_commit_ctrl
// PURPOSE
// - Reorder-buffer controller that sequences the register file. Allocates in-order ROB slots at dispatch
//   and drives the regfile update port (rename). Collects out-of-order CDB results. Retires the head
//   in order onto the regfile commit port.
// - Detects committed branch mispredictions and raises the global jump_wrong flush one cycle later.
// PARAMETERS
// - ROB_AW     4    ROB index width; equals width of the regfile ROB_pos ports
// - ROB_DEPTH  16   entries (= 2**ROB_AW)
// PORTS
// - clk            in   1   clock
// - rst            in   1   synchronous, active-high reset
// - rdy            in   1   global enable; 0 = freeze all state, suppress all valids
// - dispatch_valid in   1   decoder requests a slot
// - dispatch_rd    in   5   destination reg (0 = no writeback)
// - dispatch_br    in   1   instruction is a branch/jump
// - rob_full       out  1   count == ROB_DEPTH
// - update_valid   out  1   slot granted this cycle -> regfile rename
// - update_rd      out  5   = dispatch_rd
// - update_ROB_pos out  ROB_AW  allocated slot (= tail)
// - cdb_valid      in   1   result broadcast
// - cdb_pos        in   ROB_AW  slot being completed
// - cdb_val        in   32  result value
// - cdb_mispredict in   1   branch outcome differs from prediction
// - cdb_target     in   32  correct next PC
// - q1_pos,q2_pos  in   ROB_AW  operand lookups from decoder
// - q1_ready,q2_ready out 1  slot result available
// - q1_val,q2_val  out  32  slot result
// - commit_valid   out  1   head retires this cycle
// - commit_rd      out  5   head rd
// - commit_ROB_pos out  ROB_AW  head index
// - commit_val     out  32  head value
// - jump_wrong     out  1   registered flush pulse
// - jump_pc        out  32  redirect target, valid with jump_wrong
// BEHAVIOUR
// - Reset: head=tail=count=0; all entry ready bits 0; jump_wrong=0; jump_pc=0. All valids 0.
// - update_valid = rdy & dispatch_valid & !rob_full & !jump_wrong (combinational).
// - On grant: entry[tail] <= {rd, br, ready=0, mis=0}; tail++ with wrap at ROB_DEPTH-1 -> 0.
// - CDB (rdy=1, not flushing): entry[cdb_pos].ready<=1; val, mis, target captured.
//   A CDB to a free slot is a bench error; behaviour is unspecified.
// - commit_valid = rdy & count!=0 & entry[head].ready & !jump_wrong (combinational).
//   The regfile samples it on the same edge.
// - On commit: head++ (wrap). If the head entry is a mispredicted br: jump_wrong_q<=1, jump_pc<=target.
//   The rd write of that entry (link reg) still commits this cycle.
// - Cycle with jump_wrong=1: head=tail=count=0 and all ready bits cleared.
//   No grant, no commit, CDB ignored. jump_wrong drops next cycle (1-cycle pulse).
// - Simultaneous grant+commit: count unchanged. rob_full blocks grant even if a commit frees a slot
//   that cycle (no full bypass).
// - CDB and commit on the head in the same cycle: commit waits for the registered ready (+1 cycle).
// - q ready/val come from registered entry state only. Latency from CDB to query is 1 cycle.
// - rdy=0: every register holds, including a pending jump_wrong_q.
// - rst mid-flush: rst wins; jump_wrong clears.
// CONFIGURATION
// - ROB_FWD_EN defined: if cdb_valid & cdb_pos==qN_pos, qN_ready=1 and qN_val=cdb_val in the same
//   cycle (CDB bypass).
// - ROB_FWD_EN undefined: the query sees the result only the cycle after the CDB.
// TESTING
// - Reset, dispatch rd=5 -> update_valid=1, update_ROB_pos=0. CDB pos0 val=0x1234 -> next cycle
//   commit_valid, commit_rd=5, commit_val=0x1234.
// - 16 dispatches with no CDB -> rob_full=1, 17th update_valid=0. Complete slots out of order (3 first)
//   -> commits strictly 0,1,2,... Tail wraps 15->0.
// - Branch rd=1 at slot 2 with mispredict, target=0x80 -> commit of slot 2 writes x1.
//   Next cycle jump_wrong=1, jump_pc=0x80. Following cycle count=0, dispatch gets pos 0.
// - rdy=0 for 3 cycles during pending commit/CDB -> no valids, state identical after rdy=1.
// - Query q1_pos=4 with cdb_valid pos4 val=7: q1_ready=1, val=7 same cycle with ROB_FWD_EN,
//   next cycle without it.
// - Full ROB, head ready: commit fires, grant blocked that cycle, granted next cycle.

Source files
------------

// File: rtl/rob_commit_ctrl.sv
// Reorder-buffer controller: in-order allocation and retire, out-of-order CDB completion.
// Optional CDB-to-query bypass when the macro ROB_FWD_EN is defined.
module rob_commit_ctrl #(
    parameter int ROB_AW    = 4,
    parameter int ROB_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              dispatch_valid,
    input  logic [4:0]        dispatch_rd,
    input  logic              dispatch_br,
    output logic              rob_full,
    output logic              update_valid,
    output logic [4:0]        update_rd,
    output logic [ROB_AW-1:0] update_ROB_pos,
    input  logic              cdb_valid,
    input  logic [ROB_AW-1:0] cdb_pos,
    input  logic [31:0]       cdb_val,
    input  logic              cdb_mispredict,
    input  logic [31:0]       cdb_target,
    input  logic [ROB_AW-1:0] q1_pos,
    input  logic [ROB_AW-1:0] q2_pos,
    output logic              q1_ready,
    output logic              q2_ready,
    output logic [31:0]       q1_val,
    output logic [31:0]       q2_val,
    output logic              commit_valid,
    output logic [4:0]        commit_rd,
    output logic [ROB_AW-1:0] commit_ROB_pos,
    output logic [31:0]       commit_val,
    output logic              jump_wrong,
    output logic [31:0]       jump_pc
);

    logic [4:0]           ent_rd  [ROB_DEPTH];
    logic                 ent_br  [ROB_DEPTH];
    logic                 ent_mis [ROB_DEPTH];
    logic [31:0]          ent_val [ROB_DEPTH];
    logic [31:0]          ent_tgt [ROB_DEPTH];
    logic [ROB_DEPTH-1:0] ent_ready;

    logic [ROB_AW-1:0] head;
    logic [ROB_AW-1:0] tail;
    logic [ROB_AW:0]   count;
    logic              jump_wrong_q;
    logic [31:0]       jump_pc_q;

    function automatic logic [ROB_AW-1:0] next_idx(input logic [ROB_AW-1:0] idx);
        return (idx == ROB_AW'(ROB_DEPTH - 1)) ? '0 : idx + ROB_AW'(1);
    endfunction

    assign rob_full       = (count == (ROB_AW + 1)'(ROB_DEPTH));
    assign update_valid   = rdy & dispatch_valid & ~rob_full & ~jump_wrong_q;
    assign update_rd      = dispatch_rd;
    assign update_ROB_pos = tail;

    // Retire waits on the registered ready bit, so a same-cycle CDB on the head commits one cycle later.
    assign commit_valid   = rdy & (count != '0) & ent_ready[head] & ~jump_wrong_q;
    assign commit_rd      = ent_rd[head];
    assign commit_ROB_pos = head;
    assign commit_val     = ent_val[head];
    assign jump_wrong     = jump_wrong_q;
    assign jump_pc        = jump_pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            ent_ready    <= '0;
            jump_wrong_q <= 1'b0;
            jump_pc_q    <= '0;
        end else if (rdy) begin
            if (jump_wrong_q) begin
                head         <= '0;
                tail         <= '0;
                count        <= '0;
                ent_ready    <= '0;
                jump_wrong_q <= 1'b0;
            end else begin
                if (cdb_valid)
                    ent_ready[cdb_pos] <= 1'b1;
                if (update_valid) begin
                    ent_ready[tail] <= 1'b0;
                    tail            <= next_idx(tail);
                end
                if (commit_valid) begin
                    head <= next_idx(head);
                    if (ent_br[head] && ent_mis[head]) begin
                        jump_wrong_q <= 1'b1;
                        jump_pc_q    <= ent_tgt[head];
                    end
                end
                count <= count + (ROB_AW + 1)'(update_valid) - (ROB_AW + 1)'(commit_valid);
            end
        end
    end

    // Payload storage needs no reset: validity is tracked by count and ent_ready.
    always_ff @(posedge clk) begin
        if (!rst && rdy && !jump_wrong_q) begin
            if (update_valid) begin
                ent_rd[tail]  <= dispatch_rd;
                ent_br[tail]  <= dispatch_br;
                ent_mis[tail] <= 1'b0;
            end
            if (cdb_valid) begin
                ent_val[cdb_pos] <= cdb_val;
                ent_mis[cdb_pos] <= cdb_mispredict;
                ent_tgt[cdb_pos] <= cdb_target;
            end
        end
    end

    always_comb begin
        q1_ready = ent_ready[q1_pos];
        q1_val   = ent_val[q1_pos];
        q2_ready = ent_ready[q2_pos];
        q2_val   = ent_val[q2_pos];
`ifdef ROB_FWD_EN
        if (cdb_valid && cdb_pos == q1_pos) begin
            q1_ready = 1'b1;
            q1_val   = cdb_val;
        end
        if (cdb_valid && cdb_pos == q2_pos) begin
            q2_ready = 1'b1;
            q2_val   = cdb_val;
        end
`endif
    end

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Bench for rob_commit_ctrl: directed vector table, corner-case sequences and
// randomized traffic against a queue-based ROB model.
module tb_rob_commit_ctrl;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
`ifdef ROB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, rdy, dispatch_valid, dispatch_br;
    logic [4:0]  dispatch_rd;
    logic        rob_full, update_valid;
    logic [4:0]  update_rd;
    logic [3:0]  update_ROB_pos;
    logic        cdb_valid, cdb_mispredict;
    logic [3:0]  cdb_pos;
    logic [31:0] cdb_val, cdb_target;
    logic [3:0]  q1_pos, q2_pos;
    logic        q1_ready, q2_ready;
    logic [31:0] q1_val, q2_val;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [3:0]  commit_ROB_pos;
    logic [31:0] commit_val;
    logic        jump_wrong;
    logic [31:0] jump_pc;

    always #5 clk = ~clk;

    rob_commit_ctrl #(.ROB_AW(AW), .ROB_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .dispatch_valid(dispatch_valid), .dispatch_rd(dispatch_rd), .dispatch_br(dispatch_br),
        .rob_full(rob_full), .update_valid(update_valid), .update_rd(update_rd),
        .update_ROB_pos(update_ROB_pos),
        .cdb_valid(cdb_valid), .cdb_pos(cdb_pos), .cdb_val(cdb_val),
        .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
        .q1_pos(q1_pos), .q2_pos(q2_pos), .q1_ready(q1_ready), .q2_ready(q2_ready),
        .q1_val(q1_val), .q2_val(q2_val),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_ROB_pos(commit_ROB_pos),
        .commit_val(commit_val), .jump_wrong(jump_wrong), .jump_pc(jump_pc)
    );

    typedef struct packed {
        logic        rst;
        logic        rdy;
        logic        dv;
        logic [4:0]  rd;
        logic        br;
        logic        cv;
        logic [3:0]  cpos;
        logic [31:0] cval;
        logic        cmis;
        logic [31:0] ctgt;
        logic [3:0]  q1;
        logic [3:0]  q2;
    } stim_t;

    typedef struct packed {
        stim_t       s;
        logic        eu;
        logic [3:0]  epos;
        logic        ec;
        logic [4:0]  erd;
        logic [31:0] eval;
        logic [3:0]  ecpos;
        logic        ejw;
        logic [31:0] ejpc;
        logic        efull;
    } vec_t;

    typedef struct {
        logic [3:0]  pos;
        logic [4:0]  rd;
        logic        br;
        logic        done;
        logic [31:0] val;
        logic        mis;
        logic [31:0] tgt;
    } ent_t;

    int nChecks = 0;
    int nFail   = 0;

    ent_t        mq[$];
    int          mAlloc;
    bit          mJw;
    logic [31:0] mJpc;

    function automatic stim_t mk(input int r, input int dv, input int rd, input int br,
                                 input int cv, input int cp, input logic [31:0] cval,
                                 input int cm, input logic [31:0] ct);
        stim_t s;
        s.rst  = 1'(r);
        s.rdy  = 1'b1;
        s.dv   = 1'(dv);
        s.rd   = 5'(rd);
        s.br   = 1'(br);
        s.cv   = 1'(cv);
        s.cpos = 4'(cp);
        s.cval = cval;
        s.cmis = 1'(cm);
        s.ctgt = ct;
        s.q1   = 4'd0;
        s.q2   = 4'd0;
        return s;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        @(negedge clk);
        rst            = s.rst;
        rdy            = s.rdy;
        dispatch_valid = s.dv;
        dispatch_rd    = s.rd;
        dispatch_br    = s.br;
        cdb_valid      = s.cv;
        cdb_pos        = s.cpos;
        cdb_val        = s.cval;
        cdb_mispredict = s.cmis;
        cdb_target     = s.ctgt;
        q1_pos         = s.q1;
        q2_pos         = s.q2;
        #1;
    endtask

    task automatic checkGrant(input string name, input logic eu, input logic [3:0] epos);
        checkOutput({name, " update_valid"}, 32'(update_valid), 32'(eu));
        if (eu) checkOutput({name, " update_ROB_pos"}, 32'(update_ROB_pos), 32'(epos));
    endtask

    task automatic checkCommit(input string name, input logic ec, input logic [4:0] erd,
                               input logic [31:0] ev, input logic [3:0] epos);
        checkOutput({name, " commit_valid"}, 32'(commit_valid), 32'(ec));
        if (ec) begin
            checkOutput({name, " commit_rd"}, 32'(commit_rd), 32'(erd));
            checkOutput({name, " commit_val"}, commit_val, ev);
            checkOutput({name, " commit_ROB_pos"}, 32'(commit_ROB_pos), 32'(epos));
        end
    endtask

    task automatic doReset();
        applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    function automatic stim_t idle();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic checkQuery(input string name, input stim_t s, input logic [3:0] pos,
                              input logic act_rdy, input logic [31:0] act_val);
        if (FWD && s.cv && s.cpos == pos) begin
            checkOutput({name, " bypass ready"}, 32'(act_rdy), 32'd1);
            checkOutput({name, " bypass val"}, act_val, s.cval);
        end else begin
            foreach (mq[k]) begin
                if (mq[k].pos == pos) begin
                    checkOutput({name, " ready"}, 32'(act_rdy), 32'(mq[k].done));
                    if (mq[k].done) checkOutput({name, " val"}, act_val, mq[k].val);
                end
            end
        end
    endtask

    task automatic runRandom(input int cycles);
        mq.delete();
        mAlloc = 0;
        mJw    = 1'b0;
        mJpc   = '0;
        doReset();
        for (int n = 0; n < cycles; n++) begin
            stim_t s;
            int    cand[$];
            bit    full, eu, ec;
            s      = idle();
            s.rst  = ($urandom_range(0, 199) == 0);
            s.rdy  = ($urandom_range(0, 99) < 85);
            s.dv   = ($urandom_range(0, 99) < 60);
            s.rd   = 5'($urandom);
            s.br   = ($urandom_range(0, 99) < 30);
            foreach (mq[k]) if (!mq[k].done) cand.push_back(k);
            if (cand.size() != 0 && $urandom_range(0, 99) < 60) begin
                s.cv   = 1'b1;
                s.cpos = mq[cand[$urandom_range(0, cand.size() - 1)]].pos;
                s.cval = $urandom;
                s.cmis = ($urandom_range(0, 99) < 25);
                s.ctgt = $urandom & 32'hFFFF_FFFC;
            end
            s.q1 = (mq.size() != 0) ? mq[$urandom_range(0, mq.size() - 1)].pos : 4'($urandom);
            s.q2 = (mq.size() != 0) ? mq[$urandom_range(0, mq.size() - 1)].pos : 4'($urandom);
            applyStimulus(s);

            full = (mq.size() == DEPTH);
            eu   = s.rdy && s.dv && !full && !mJw;
            ec   = s.rdy && mq.size() != 0 && mq[0].done && !mJw;
            checkOutput("rnd rob_full", 32'(rob_full), 32'(full));
            checkGrant("rnd", eu, 4'(mAlloc));
            if (eu) checkOutput("rnd update_rd", 32'(update_rd), 32'(s.rd));
            if (mq.size() != 0) checkCommit("rnd", ec, mq[0].rd, mq[0].val, mq[0].pos);
            else checkOutput("rnd commit_valid empty", 32'(commit_valid), 32'd0);
            checkOutput("rnd jump_wrong", 32'(jump_wrong), 32'(mJw));
            checkOutput("rnd jump_pc", jump_pc, mJpc);
            checkQuery("rnd q1", s, s.q1, q1_ready, q1_val);
            checkQuery("rnd q2", s, s.q2, q2_ready, q2_val);

            if (s.rst) begin
                mq.delete();
                mAlloc = 0;
                mJw    = 1'b0;
                mJpc   = '0;
            end else if (s.rdy) begin
                if (mJw) begin
                    mq.delete();
                    mAlloc = 0;
                    mJw    = 1'b0;
                end else begin
                    if (s.cv) begin
                        foreach (mq[k]) begin
                            if (mq[k].pos == s.cpos) begin
                                mq[k].done = 1'b1;
                                mq[k].val  = s.cval;
                                mq[k].mis  = s.cmis;
                                mq[k].tgt  = s.ctgt;
                            end
                        end
                    end
                    if (ec) begin
                        if (mq[0].br && mq[0].mis) begin
                            mJw  = 1'b1;
                            mJpc = mq[0].tgt;
                        end
                        void'(mq.pop_front());
                    end
                    if (eu) begin
                        mq.push_back('{pos: 4'(mAlloc), rd: s.rd, br: s.br, done: 1'b0,
                                       val: '0, mis: 1'b0, tgt: '0});
                        mAlloc = (mAlloc + 1) % DEPTH;
                    end
                end
            end
        end
    endtask

    initial begin
        vec_t  tbl[15];
        stim_t s;

        rst = 1'b1; rdy = 1'b0; dispatch_valid = 1'b0; dispatch_rd = '0; dispatch_br = 1'b0;
        cdb_valid = 1'b0; cdb_pos = '0; cdb_val = '0; cdb_mispredict = 1'b0; cdb_target = '0;
        q1_pos = '0; q2_pos = '0;

        // Basic dispatch/complete/commit, then a mispredicted branch at slot 2 and its flush.
        tbl[0]  = '{idle(),                                    0, 0, 0, 0, 0,      0, 0, 0,     0};
        tbl[1]  = '{mk(0, 1, 5, 0, 0, 0, 0, 0, 0),             1, 0, 0, 0, 0,      0, 0, 0,     0};
        tbl[2]  = '{mk(0, 0, 0, 0, 1, 0, 32'h1234, 0, 0),      0, 0, 0, 0, 0,      0, 0, 0,     0};
        tbl[3]  = '{idle(),                                    0, 0, 1, 5, 32'h1234, 0, 0, 0,   0};
        tbl[4]  = '{idle(),                                    0, 0, 0, 0, 0,      0, 0, 0,     0};
        tbl[5]  = '{mk(1, 0, 0, 0, 0, 0, 0, 0, 0),             0, 0, 0, 0, 0,      0, 0, 0,     0};
        tbl[6]  = '{mk(0, 1, 3, 0, 0, 0, 0, 0, 0),             1, 0, 0, 0, 0,      0, 0, 0,     0};
        tbl[7]  = '{mk(0, 1, 4, 0, 0, 0, 0, 0, 0),             1, 1, 0, 0, 0,      0, 0, 0,     0};
        tbl[8]  = '{mk(0, 1, 1, 1, 1, 0, 32'h11, 0, 0),        1, 2, 0, 0, 0,      0, 0, 0,     0};
        tbl[9]  = '{mk(0, 0, 0, 0, 1, 2, 32'h44, 1, 32'h80),   0, 0, 1, 3, 32'h11, 0, 0, 0,     0};
        tbl[10] = '{mk(0, 0, 0, 0, 1, 1, 32'h22, 0, 0),        0, 0, 0, 0, 0,      0, 0, 0,     0};
        tbl[11] = '{idle(),                                    0, 0, 1, 4, 32'h22, 1, 0, 0,     0};
        tbl[12] = '{mk(0, 1, 9, 0, 0, 0, 0, 0, 0),             1, 3, 1, 1, 32'h44, 2, 0, 0,     0};
        tbl[13] = '{mk(0, 1, 9, 0, 0, 0, 0, 0, 0),             0, 0, 0, 0, 0,      0, 1, 32'h80, 0};
        tbl[14] = '{mk(0, 1, 7, 0, 0, 0, 0, 0, 0),             1, 0, 0, 0, 0,      0, 0, 32'h80, 0};

        doReset();
        foreach (tbl[i]) begin
            string nm;
            applyStimulus(tbl[i].s);
            nm = $sformatf("vec%0d", i);
            checkGrant(nm, tbl[i].eu, tbl[i].epos);
            checkCommit(nm, tbl[i].ec, tbl[i].erd, tbl[i].eval, tbl[i].ecpos);
            checkOutput({nm, " jump_wrong"}, 32'(jump_wrong), 32'(tbl[i].ejw));
            checkOutput({nm, " jump_pc"}, jump_pc, tbl[i].ejpc);
            checkOutput({nm, " rob_full"}, 32'(rob_full), 32'(tbl[i].efull));
        end

        // Fill all 16 slots, complete out of order, retire in order, tail wraps 15 -> 0.
        doReset();
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(mk(0, 1, i + 1, 0, 0, 0, 0, 0, 0));
            checkOutput("fill rob_full", 32'(rob_full), 32'd0);
            checkGrant("fill", 1'b1, 4'(i));
        end
        applyStimulus(mk(0, 1, 20, 0, 0, 0, 0, 0, 0));
        checkOutput("full rob_full", 32'(rob_full), 32'd1);
        checkGrant("full 17th", 1'b0, 4'd0);
        applyStimulus(mk(0, 0, 0, 0, 1, 3, 32'h300, 0, 0));
        checkCommit("ooo slot3 first", 1'b0, 0, 0, 0);
        applyStimulus(mk(0, 0, 0, 0, 1, 0, 32'h100, 0, 0));
        checkCommit("ooo slot0 cdb", 1'b0, 0, 0, 0);
        applyStimulus(mk(0, 1, 21, 0, 0, 0, 0, 0, 0));
        checkOutput("full+commit rob_full", 32'(rob_full), 32'd1);
        checkCommit("full+commit", 1'b1, 5'd1, 32'h100, 4'd0);
        checkGrant("full+commit blocked", 1'b0, 4'd0);
        applyStimulus(mk(0, 1, 21, 0, 1, 2, 32'h200, 0, 0));
        checkGrant("wrap grant", 1'b1, 4'd0);
        checkCommit("wrap no commit", 1'b0, 0, 0, 0);
        applyStimulus(mk(0, 0, 0, 0, 1, 1, 32'h101, 0, 0));
        checkCommit("head cdb same cycle", 1'b0, 0, 0, 0);
        applyStimulus(idle());
        checkCommit("inorder 1", 1'b1, 5'd2, 32'h101, 4'd1);
        applyStimulus(idle());
        checkCommit("inorder 2", 1'b1, 5'd3, 32'h200, 4'd2);
        applyStimulus(idle());
        checkCommit("inorder 3", 1'b1, 5'd4, 32'h300, 4'd3);
        applyStimulus(idle());
        checkCommit("inorder stop", 1'b0, 0, 0, 0);

        // Three frozen cycles while a commit is pending and a CDB is presented.
        doReset();
        applyStimulus(mk(0, 1, 6, 0, 0, 0, 0, 0, 0));
        checkGrant("frz pre0", 1'b1, 4'd0);
        applyStimulus(mk(0, 1, 8, 0, 1, 0, 32'h55, 0, 0));
        checkGrant("frz pre1", 1'b1, 4'd1);
        for (int i = 0; i < 3; i++) begin
            s     = mk(0, 1, 10, 0, 1, 1, 32'h99, 0, 0);
            s.rdy = 1'b0;
            applyStimulus(s);
            checkGrant("frz", 1'b0, 4'd0);
            checkOutput("frz commit_valid", 32'(commit_valid), 32'd0);
        end
        applyStimulus(idle());
        checkCommit("frz resume", 1'b1, 5'd6, 32'h55, 4'd0);
        applyStimulus(idle());
        checkCommit("frz cdb ignored", 1'b0, 0, 0, 0);
        applyStimulus(mk(0, 1, 11, 0, 0, 0, 0, 0, 0));
        checkGrant("frz tail held", 1'b1, 4'd2);

        // Operand query on slot 4 while its result is on the CDB.
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(mk(0, 1, i + 1, 0, 0, 0, 0, 0, 0));
        s    = mk(0, 0, 0, 0, 1, 4, 32'h7, 0, 0);
        s.q1 = 4'd4;
        s.q2 = 4'd3;
        applyStimulus(s);
        checkOutput("query same-cycle q1_ready", 32'(q1_ready), 32'(FWD));
        checkOutput("query same-cycle q2_ready", 32'(q2_ready), 32'd0);
        s    = idle();
        s.q1 = 4'd4;
        s.q2 = 4'd3;
        applyStimulus(s);
        checkOutput("query next-cycle q1_ready", 32'(q1_ready), 32'd1);
        checkOutput("query next-cycle q1_val", q1_val, 32'h7);
        checkOutput("query next-cycle q2_ready", 32'(q2_ready), 32'd0);

        runRandom(3000);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
